fractcam_prio_enc: RTL and testbench
====================================

Name: fractcam_prio_enc

Overview:
- Downstream of fractcam_top. Consumes the TCAM_DEPTH-bit match vector and produces the index of the highest-priority matching rule.
- Lowest index has highest priority.
- Two-stage registered priority-encoder tree with a valid/ready handshake on both sides.
- Provides a multi-hit flag and saturating hit/miss statistics counters for the lookup datapath.

Parameters:
- TCAM_DEPTH, 1024, number of rules (match vector width); power of 2, multiple of GROUP_WIDTH.
- GROUP_WIDTH, 32, bits per first-stage encoder group; power of 2, at least 2.
- CNT_WIDTH, 32, width of the statistics counters.
- Localparams:
  - ADDR_WIDTH = max(clog2(TCAM_DEPTH), 1)
  - GROUPS = TCAM_DEPTH/GROUP_WIDTH
  - LOCAL_WIDTH = clog2(GROUP_WIDTH)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- match  in  TCAM_DEPTH  match vector from fractcam; bit i set = rule i hit
- match_valid  in  1  match vector valid
- match_ready  out  1  block accepts match this cycle
- m_index  out  ADDR_WIDTH  lowest set bit index of the accepted match
- m_hit  out  1  at least one bit was set
- m_multi  out  1  more than one bit was set
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- stat_clear  in  1  synchronous clear of both counters
- hit_count  out  CNT_WIDTH  results delivered with m_hit=1
- miss_count  out  CNT_WIDTH  results delivered with m_hit=0

Behaviour:
- Reset (async, asserted immediately): s1_valid, m_valid, m_index, m_hit, m_multi, hit_count and miss_count all go to 0. Stage-1 payload registers also go to 0.
- Global advance enable: en = !m_valid || m_ready. match_ready = en, combinational.
- Both stages shift together when en=1. When en=0 all registers hold, so m_* stays stable while m_valid && !m_ready.
- Stage 1 (on en): s1_valid <= match_valid. For each group g, register:
  - grp_hit[g] = OR of the group's bits
  - grp_multi[g] = more than one bit set in the group
  - grp_idx[g] = lowest set bit position within the group (0 if none)
  - When match_valid=0 on an enabled cycle, the payload may update but is ignored.
- Stage 2 (on en): m_valid <= s1_valid. When s1_valid=1:
  - g* = lowest g with grp_hit[g]
  - m_hit = OR(grp_hit)
  - m_index = {g*, grp_idx[g*]}
  - m_multi = grp_multi[g*] OR (count(grp_hit) > 1)
  - On a miss: m_index = 0, m_hit = 0, m_multi = 0.
- Latency: 2 cycles from accept (match_valid && match_ready) to m_valid, with no stall. Throughput is one result per cycle. Bubbles propagate as m_valid=0. Results are delivered in order; none are dropped or duplicated.
- Statistics:
  - On output handshake (m_valid && m_ready): hit_count += 1 if m_hit, else miss_count += 1.
  - Counters saturate at all-ones and do not wrap.
  - stat_clear=1 zeros both counters and wins over a same-cycle increment.
- Boundary conditions:
  - GROUPS=1 degenerates to a single group; g* = 0.
  - All-ones match gives index 0, multi 1.
  - Bit TCAM_DEPTH-1 alone gives index TCAM_DEPTH-1.
  - Reset mid-stream discards all in-flight results.
  - match_valid while en=0 is not accepted; the source must hold it.

Test Plan:
- match=bit0 only, m_ready=1 → exactly 2 cycles later m_valid=1, m_index=0, m_hit=1, m_multi=0; hit_count=1.
- match bits {37,1023} → m_index=37, m_hit=1, m_multi=1. match=bit1023 only → m_index=1023, m_multi=0.
- Group boundary: match bits {31,32} → m_index=31, m_multi=1. match=bit32 only → m_index=32, m_multi=0.
- match=0 → m_hit=0, m_index=0, m_multi=0; miss_count increments by 1, hit_count unchanged.
- Three back-to-back searches (bits 5, 600, none) with m_ready=0 for 4 cycles:
  - match_ready=0 while m_valid=1 and m_index=5 is held stable.
  - After release, results 5, 600, miss arrive in order.
  - hit_count=2, miss_count=1.
- Reset behaviour:
  - rst pulsed mid-stream → m_valid and counters read 0 in the same cycle, with no stale result afterwards.
  - stat_clear coincident with a handshake → counter reads 0.
  - Preload the counter to all-ones minus 1, then apply 2 hits → hit_count saturates at all-ones.

Source files
------------

// File: rtl/fractcam_prio_enc.sv
// Two-stage priority encoder for the fractcam match vector: per-group encode, then group select.
// Lowest set bit wins; also reports multi-hit and keeps saturating hit/miss counters.
module fractcam_prio_enc #(
   parameter int TCAM_DEPTH  = 1024,
   parameter int GROUP_WIDTH = 32,
   parameter int CNT_WIDTH   = 32,
   localparam int ADDR_WIDTH  = (TCAM_DEPTH > 1) ? $clog2(TCAM_DEPTH) : 1,
   localparam int GROUPS      = TCAM_DEPTH / GROUP_WIDTH,
   localparam int LOCAL_WIDTH = $clog2(GROUP_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [TCAM_DEPTH-1:0] match,
   input  logic                  match_valid,
   output logic                  match_ready,
   output logic [ADDR_WIDTH-1:0] m_index,
   output logic                  m_hit,
   output logic                  m_multi,
   output logic                  m_valid,
   input  logic                  m_ready,
   input  logic                  stat_clear,
   output logic [CNT_WIDTH-1:0]  hit_count,
   output logic [CNT_WIDTH-1:0]  miss_count
);

   function automatic logic [LOCAL_WIDTH-1:0] lowest_idx(input logic [GROUP_WIDTH-1:0] v);
      logic [LOCAL_WIDTH-1:0] idx;
      idx = '0;
      for (int i = GROUP_WIDTH - 1; i >= 0; i--) begin
         if (v[i]) idx = LOCAL_WIDTH'(i);
      end
      return idx;
   endfunction

   function automatic logic grp_multi_set(input logic [GROUP_WIDTH-1:0] v);
      return |(v & (v - GROUP_WIDTH'(1)));
   endfunction

   function automatic logic hit_multi_set(input logic [GROUPS-1:0] v);
      return |(v & (v - GROUPS'(1)));
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (&c) ? c : c + CNT_WIDTH'(1);
   endfunction

   logic                                  w_en;
   logic                                  r_s1_valid;
   logic [GROUPS-1:0]                     r_grp_hit;
   logic [GROUPS-1:0]                     r_grp_multi;
   logic [GROUPS-1:0][LOCAL_WIDTH-1:0]    r_grp_idx;

   logic [ADDR_WIDTH-1:0]                 w_sel_index;
   logic                                  w_sel_multi;
   logic                                  w_hit;
   logic                                  w_multi;

   logic                                  r_m_valid;
   logic [ADDR_WIDTH-1:0]                 r_m_index;
   logic                                  r_m_hit;
   logic                                  r_m_multi;
   logic [CNT_WIDTH-1:0]                  r_hit_count;
   logic [CNT_WIDTH-1:0]                  r_miss_count;

   // Whole pipeline advances in lockstep; a stalled output freezes both stages.
   assign w_en        = !r_m_valid || m_ready;
   assign match_ready = w_en;

   // Stage 1: per-group hit, multi-hit and local lowest index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_grp_hit   <= '0;
         r_grp_multi <= '0;
         r_grp_idx   <= '0;
      end else if (w_en) begin
         r_s1_valid <= match_valid;
         for (int g = 0; g < GROUPS; g++) begin
            r_grp_hit[g]   <= |match[g*GROUP_WIDTH +: GROUP_WIDTH];
            r_grp_multi[g] <= grp_multi_set(match[g*GROUP_WIDTH +: GROUP_WIDTH]);
            r_grp_idx[g]   <= lowest_idx(match[g*GROUP_WIDTH +: GROUP_WIDTH]);
         end
      end
   end

   // Stage 2: pick the lowest hitting group and splice its local index in
   always_comb begin
      w_sel_index = '0;
      w_sel_multi = 1'b0;
      for (int g = GROUPS - 1; g >= 0; g--) begin
         if (r_grp_hit[g]) begin
            w_sel_index = ADDR_WIDTH'(g * GROUP_WIDTH) | ADDR_WIDTH'(r_grp_idx[g]);
            w_sel_multi = r_grp_multi[g];
         end
      end
      w_hit   = |r_grp_hit;
      w_multi = w_hit && (w_sel_multi || hit_multi_set(r_grp_hit));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m_valid <= 1'b0;
         r_m_index <= '0;
         r_m_hit   <= 1'b0;
         r_m_multi <= 1'b0;
      end else if (w_en) begin
         r_m_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_m_index <= w_sel_index;
            r_m_hit   <= w_hit;
            r_m_multi <= w_multi;
         end
      end
   end

   // Statistics: clear beats a same-cycle increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else if (stat_clear) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else if (r_m_valid && m_ready) begin
         if (r_m_hit) r_hit_count  <= sat_inc(r_hit_count);
         else         r_miss_count <= sat_inc(r_miss_count);
      end
   end

   assign m_valid    = r_m_valid;
   assign m_index    = r_m_index;
   assign m_hit      = r_m_hit;
   assign m_multi    = r_m_multi;
   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;

endmodule

// File: tb/tb_fractcam_prio_enc.sv
// Directed bench for fractcam_prio_enc with an in-order result scoreboard.
module tb_fractcam_prio_enc;

   localparam int DEPTH = 1024;
   localparam int AW    = 10;
   localparam int CW    = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [DEPTH-1:0] match;
   logic             match_valid;
   logic             match_ready;
   logic [AW-1:0]    m_index;
   logic             m_hit;
   logic             m_multi;
   logic             m_valid;
   logic             m_ready;
   logic             stat_clear;
   logic [CW-1:0]    hit_count;
   logic [CW-1:0]    miss_count;

   typedef struct {
      logic [AW-1:0] idx;
      logic          hit;
      logic          multi;
   } exp_t;

   exp_t q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   fractcam_prio_enc #(
      .TCAM_DEPTH (DEPTH),
      .GROUP_WIDTH(32),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .match      (match),
      .match_valid(match_valid),
      .match_ready(match_ready),
      .m_index    (m_index),
      .m_hit      (m_hit),
      .m_multi    (m_multi),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .stat_clear (stat_clear),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [DEPTH-1:0] v);
      exp_t r;
      int   n;
      n     = 0;
      r.idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (v[i]) begin
            r.idx = AW'(i);
            n++;
         end
      end
      r.hit   = (n > 0);
      r.multi = (n > 1);
      return r;
   endfunction

   // Handshakes are evaluated mid-cycle, ahead of the posedge where they take effect.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         if (m_valid && m_ready) begin
            if (q.size() == 0) begin
               check("sb_unexpected_result", 32'(m_valid), 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("sb_index", 32'(m_index), 32'(e.idx));
               check("sb_hit",   32'(m_hit),   32'(e.hit));
               check("sb_multi", 32'(m_multi), 32'(e.multi));
            end
         end
         if (match_valid && match_ready) q.push_back(model(match));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_one(input logic [DEPTH-1:0] v);
      tick();
      match       = v;
      match_valid = 1'b1;
      tick();
      match_valid = 1'b0;
      match       = '0;
      repeat (3) tick();
   endtask

   function automatic logic [DEPTH-1:0] bits2(input int a, input int b);
      logic [DEPTH-1:0] v;
      v    = '0;
      v[a] = 1'b1;
      v[b] = 1'b1;
      return v;
   endfunction

   function automatic logic [DEPTH-1:0] bit1(input int a);
      logic [DEPTH-1:0] v;
      v    = '0;
      v[a] = 1'b1;
      return v;
   endfunction

   initial begin
      logic [DEPTH-1:0] v;
      rst         = 1'b1;
      match       = '0;
      match_valid = 1'b0;
      m_ready     = 1'b1;
      stat_clear  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_m_valid", 32'(m_valid),    32'd0);
      check("rst_m_index", 32'(m_index),    32'd0);
      check("rst_hit_cnt", 32'(hit_count),  32'd0);
      check("rst_miss_cnt", 32'(miss_count), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Two-cycle latency on bit 0
      match       = bit1(0);
      match_valid = 1'b1;
      tick();
      match_valid = 1'b0;
      match       = '0;
      @(negedge clk);
      check("lat_cycle1_valid", 32'(m_valid), 32'd0);
      tick();
      @(negedge clk);
      check("lat_cycle2_valid", 32'(m_valid), 32'd1);
      check("lat_index",        32'(m_index), 32'd0);
      check("lat_multi",        32'(m_multi), 32'd0);
      tick();
      @(negedge clk);
      check("lat_hit_cnt", 32'(hit_count), 32'd1);
      repeat (2) tick();

      send_one(bits2(37, 1023));
      send_one(bit1(1023));
      send_one(bits2(31, 32));
      send_one(bit1(32));
      @(negedge clk);
      check("pre_miss_hit_cnt",  32'(hit_count),  32'd5);
      check("pre_miss_miss_cnt", 32'(miss_count), 32'd0);
      send_one('0);
      @(negedge clk);
      check("miss_hit_cnt",  32'(hit_count),  32'd5);
      check("miss_miss_cnt", 32'(miss_count), 32'd1);

      // Back-pressure: 5, 600, miss with output stalled
      tick();
      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;
      @(negedge clk);
      check("clr_hit_cnt", 32'(hit_count), 32'd0);
      tick();
      m_ready     = 1'b0;
      match       = bit1(5);
      match_valid = 1'b1;
      tick();
      match = bit1(600);
      tick();
      match = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_match_ready", 32'(match_ready), 32'd0);
         check("stall_m_valid",     32'(m_valid),     32'd1);
         check("stall_m_index",     32'(m_index),     32'd5);
         tick();
      end
      m_ready = 1'b1;
      tick();
      match_valid = 1'b0;
      repeat (4) tick();
      @(negedge clk);
      check("stall_hit_cnt",  32'(hit_count),  32'd2);
      check("stall_miss_cnt", 32'(miss_count), 32'd1);
      check("stall_sb_empty", 32'(q.size()),   32'd0);

      // Reset with two results in flight
      match       = bit1(7);
      match_valid = 1'b1;
      tick();
      match = bit1(8);
      tick();
      match_valid = 1'b0;
      match       = '0;
      #2;
      rst = 1'b1;
      #1;
      check("midrst_m_valid",  32'(m_valid),    32'd0);
      check("midrst_hit_cnt",  32'(hit_count),  32'd0);
      check("midrst_miss_cnt", 32'(miss_count), 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("postrst_no_stale", 32'(m_valid), 32'd0);
      end
      tick();

      // Clear coinciding with an output handshake
      match       = bit1(3);
      match_valid = 1'b1;
      tick();
      match_valid = 1'b0;
      match       = '0;
      tick();
      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;
      @(negedge clk);
      check("clr_vs_inc_hit_cnt", 32'(hit_count), 32'd0);
      repeat (2) tick();

      // Stream 14 hits to reach all-ones minus one, then 2 more must saturate
      for (int i = 0; i < 14; i++) begin
         v = bit1(int'($urandom_range(DEPTH - 1, 0)));
         if (i % 3 == 1) v[$urandom_range(DEPTH - 1, 0)] = 1'b1;
         match       = v;
         match_valid = 1'b1;
         tick();
      end
      match_valid = 1'b0;
      match       = '0;
      repeat (4) tick();
      @(negedge clk);
      check("sat_pre_hit_cnt", 32'(hit_count), 32'd14);
      match       = '1;
      match_valid = 1'b1;
      tick();
      match = bit1(1023);
      tick();
      match_valid = 1'b0;
      match       = '0;
      repeat (4) tick();
      @(negedge clk);
      check("sat_hit_cnt",  32'(hit_count),  32'd15);
      check("sat_miss_cnt", 32'(miss_count), 32'd0);
      check("final_sb_empty", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
